// File: rtl/mem_ctrl.sv
// Two-port block memory controller: round-robin arbitration between two cache
// ports, a fixed access latency, and a registered one-cycle success pulse.
module mem_ctrl #(
   parameter int ADDRESSBIT = 32,
   parameter int WORDSIZE   = 8,
   parameter int BLOCKBYTE  = 4,
   parameter int MEMBLOCKS  = 256,
   parameter int LATENCY    = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req0,
   input  logic                            req1,
   input  logic                            rw0,
   input  logic                            rw1,
   input  logic [ADDRESSBIT-1:0]           addr0,
   input  logic [ADDRESSBIT-1:0]           addr1,
   input  logic [WORDSIZE*BLOCKBYTE-1:0]   wdata0,
   input  logic [WORDSIZE*BLOCKBYTE-1:0]   wdata1,
   output logic [WORDSIZE*BLOCKBYTE-1:0]   rdata0,
   output logic [WORDSIZE*BLOCKBYTE-1:0]   rdata1,
   output logic                            success0,
   output logic                            success1
);

   localparam int BW   = WORDSIZE * BLOCKBYTE;
   localparam int OFFB = $clog2(BLOCKBYTE);
   localparam int IDXB = (MEMBLOCKS > 1) ? $clog2(MEMBLOCKS) : 1;
   localparam int CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            pri;        // port to favour on the next tie
   logic            sel;        // port owning the current transaction
   logic            lat_rw;
   logic [IDXB-1:0] lat_idx;
   logic [BW-1:0]   lat_wdata;
   logic [BW-1:0]   mem [MEMBLOCKS];

   logic [IDXB-1:0] idx0, idx1;
   logic            gnt;
   logic            commit;
   logic            unused_addr;

   // Offset and excess upper address bits alias onto the same block.
   assign idx0        = addr0[OFFB +: IDXB];
   assign idx1        = addr1[OFFB +: IDXB];
   assign unused_addr = ^{addr0, addr1};

   assign gnt    = (req0 && req1) ? pri : req1;
   assign commit = (state == BUSY) && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         pri       <= 1'b0;
         sel       <= 1'b0;
         lat_rw    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
         success0  <= 1'b0;
         success1  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  sel       <= gnt;
                  pri       <= ~gnt;
                  lat_rw    <= gnt ? rw1 : rw0;
                  lat_idx   <= gnt ? idx1 : idx0;
                  lat_wdata <= gnt ? wdata1 : wdata0;
                  cnt       <= CW'(LATENCY - 1);
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  if (!lat_rw) begin
                     if (sel) rdata1 <= mem[lat_idx];
                     else     rdata0 <= mem[lat_idx];
                  end
                  success0 <= ~sel;
                  success1 <= sel;
                  state    <= DONE;
               end
            end
            DONE: begin
               // No grant here, so a port dropping req after its pulse is never re-served.
               success0 <= 1'b0;
               success1 <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is deliberately left out of reset; an in-flight write is lost
   // because reset clears the state that drives commit.
   always_ff @(posedge clk) begin
      if (commit && lat_rw) mem[lat_idx] <= lat_wdata;
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a scoreboard of expected completions
// (port, rdata) checked against each success pulse.
module tb_mem_ctrl;

   localparam int LAT = 4;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic [31:0] rdata0, rdata1;
   logic        success0, success1;

   int tests = 0;
   int fails = 0;
   int nsucc = 0;

   typedef struct {
      bit          port;
      logic [31:0] data;
   } sb_t;
   sb_t         sb[$];
   logic [31:0] mdl [int];
   logic [31:0] rd_m [2];

   mem_ctrl #(.LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .rdata0(rdata0), .rdata1(rdata1),
      .success0(success0), .success1(success1)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every success pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      sb_t it;
      if (!rst && (success0 || success1)) begin
         check("no_overlap", {31'b0, success0 & success1}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_success", {30'b0, success1, success0}, 32'd0);
         end else begin
            it = sb.pop_front();
            check("grant_port", {31'b0, success1}, {31'b0, it.port});
            check("rdata", success1 ? rdata1 : rdata0, it.data);
            nsucc++;
         end
      end
   end

   function automatic int bidx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   task automatic drive(input bit p, input bit r, input bit rw, input logic [31:0] a, input logic [31:0] d);
      if (!p) begin req0 = r; rw0 = rw; addr0 = a; wdata0 = d; end
      else    begin req1 = r; rw1 = rw; addr1 = a; wdata1 = d; end
   endtask

   task automatic push(input bit p, input bit rw, input logic [31:0] a, input logic [31:0] d);
      sb_t it;
      if (rw) mdl[bidx(a)] = d;
      else    rd_m[p] = mdl[bidx(a)];
      it.port = p;
      it.data = rd_m[p];
      sb.push_back(it);
   endtask

   task automatic wait_succ(input bit p, input int n0, output int n);
      bit hit;
      hit = 1'b0;
      n   = n0;
      while (!hit && n < n0 + 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         hit = p ? success1 : success0;
      end
      check("success_seen", {31'b0, hit}, 32'd1);
   endtask

   task automatic txn(input string tag, input bit p, input bit rw, input logic [31:0] a, input logic [31:0] d);
      int n;
      @(negedge clk);
      push(p, rw, a, d);
      drive(p, 1'b1, rw, a, d);
      wait_succ(p, 0, n);
      check({tag, "_latency"}, n, LAT + 1);
      if (!p) req0 = 1'b0; else req1 = 1'b0;
      @(negedge clk);
      check({tag, "_one_cycle"}, {31'b0, p ? success1 : success0}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      rd_m[0] = '0;
      rd_m[1] = '0;
   endtask

   initial begin
      int n, n2, target, guard;
      rd_m[0] = '0;
      rd_m[1] = '0;

      repeat (2) @(negedge clk);
      check("rst_rdata0", rdata0, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      check("rst_succ", {30'b0, success1, success0}, 32'd0);
      rst = 1'b0;

      // Basic write/read, then aliasing of 0x404 onto index 1.
      txn("wr_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      txn("rd_10", 1'b0, 1'b0, 32'h10, 32'h0);
      txn("wr_04", 1'b1, 1'b1, 32'h04, 32'h11111111);
      txn("rd_404", 1'b0, 1'b0, 32'h404, 32'h0);

      // Inputs changed and req dropped after grant: original transaction completes.
      txn("wr_40", 1'b0, 1'b1, 32'h40, 32'h12345678);
      @(negedge clk);
      push(1'b0, 1'b1, 32'h30, 32'h55AA55AA);
      drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h55AA55AA);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h40, 32'hFFFFFFFF);
      wait_succ(1'b0, 1, n);
      check("late_change_latency", n, LAT + 1);
      txn("rd_40", 1'b1, 1'b0, 32'h40, 32'h0);
      txn("rd_30", 1'b0, 1'b0, 32'h30, 32'h0);

      // Reset two cycles into a write: nothing commits, outputs cleared.
      txn("wr_20_zero", 1'b0, 1'b1, 32'h20, 32'h0);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_succ", {30'b0, success1, success0}, 32'd0);
      check("midrst_rdata0", rdata0, 32'd0);
      check("midrst_rdata1", rdata1, 32'd0);
      req0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rd_m[0] = '0;
      rd_m[1] = '0;
      repeat (LAT + 3) begin
         @(negedge clk);
         check("midrst_no_pulse", {31'b0, success0}, 32'd0);
      end
      txn("rd_20", 1'b1, 1'b0, 32'h20, 32'h0);

      // Simultaneous requests after reset: port 0 first, port 1 LATENCY+2 later.
      do_reset();
      @(negedge clk);
      push(1'b0, 1'b0, 32'h10, 32'h0);
      push(1'b1, 1'b0, 32'h04, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h04, 32'h0);
      wait_succ(1'b0, 0, n);
      check("tie_p0_latency", n, LAT + 1);
      req0 = 1'b0;
      wait_succ(1'b1, n, n2);
      check("tie_p1_latency", n2, 2 * LAT + 3);
      req1 = 1'b0;
      @(negedge clk);

      // Held ties alternate 0,1,0,1.
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         push(1'b0, 1'b0, 32'h10, 32'h0);
         push(1'b1, 1'b0, 32'h04, 32'h0);
      end
      target = nsucc + 4;
      guard  = 0;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h04, 32'h0);
      while (nsucc < target && guard < 100) begin
         @(negedge clk);
         #1;
         guard++;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      check("rr_count", nsucc, target);
      repeat (LAT + 3) @(negedge clk);

      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
